// File: rtl/bp_fe_icache_fetch_checker.sv
// In-order fetch-return checker for the I$ under test: compares each return with the oldest expectation.
// Optional BP_FE_FETCH_CHECKER_HALT_ON_ERR_EN: the first error moves to FAIL at once and freezes the checker.
module bp_fe_icache_fetch_checker #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int els_p         = 8,
  parameter int timeout_p     = 4096,
  parameter int cnt_width_p   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         exp_v_i,
  output logic                         exp_ready_o,
  input  logic [vaddr_width_p-1:0]     exp_vaddr_i,
  input  logic [instr_width_p-1:0]     exp_instr_i,
  input  logic                         data_v_i,
  input  logic [instr_width_p-1:0]     data_i,
  input  logic                         done_i,
  output logic [$clog2(els_p+1)-1:0]   outstanding_o,
  output logic [cnt_width_p-1:0]       match_cnt_o,
  output logic [cnt_width_p-1:0]       mismatch_cnt_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic                         fail_o,
  output logic                         timeout_o,
  output logic [vaddr_width_p-1:0]     err_vaddr_o,
  output logic [instr_width_p-1:0]     err_exp_o,
  output logic [instr_width_p-1:0]     err_act_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int occ_w = $clog2(els_p+1);
  localparam int wd_w  = $clog2(timeout_p+1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PASS, FAIL} state_e;
  state_e state, state_n;

  logic [vaddr_width_p-1:0] vaddr_mem [els_p];
  logic [instr_width_p-1:0] instr_mem [els_p];
  logic [ptr_w-1:0] rd_ptr, wr_ptr;
  logic [occ_w-1:0] count;
  logic [wd_w-1:0]  wd_cnt;
  logic [vaddr_width_p-1:0] head_vaddr;
  logic [instr_width_p-1:0] head_instr;
  logic full, empty, halted, active, push, pop, hit;
  logic data_err, wd_err, err_now, err_seen;

`ifdef BP_FE_FETCH_CHECKER_HALT_ON_ERR_EN
  assign halted = (state == FAIL);
`else
  assign halted = 1'b0;
`endif

  assign active      = ~halted;
  assign full        = (count == occ_w'(els_p));
  assign empty       = (count == '0);
  assign exp_ready_o = ~full & ~halted;
  assign push        = exp_v_i & exp_ready_o;
  assign head_vaddr  = vaddr_mem[rd_ptr];
  assign head_instr  = instr_mem[rd_ptr];
  assign pop         = data_v_i & active & ~empty;
  assign hit         = pop & (head_instr == data_i);
  assign data_err    = data_v_i & active & (empty | (head_instr != data_i));
  assign wd_err      = active & ~data_v_i & ~empty & (wd_cnt == wd_w'(timeout_p-1));
  assign err_now     = data_err | wd_err;
  assign outstanding_o = count;

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      vaddr_mem[wr_ptr] <= exp_vaddr_i;
      instr_mem[wr_ptr] <= exp_instr_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      wd_cnt         <= '0;
      match_cnt_o    <= '0;
      mismatch_cnt_o <= '0;
      err_seen       <= 1'b0;
      timeout_o      <= 1'b0;
      err_vaddr_o    <= '0;
      err_exp_o      <= '0;
      err_act_o      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (hit && match_cnt_o != '1)         match_cnt_o    <= match_cnt_o + 1'b1;
      if (data_err && mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
      // Watchdog parks one past the trip point so it fires only once per stall.
      if (data_v_i || empty)               wd_cnt <= '0;
      else if (wd_cnt != wd_w'(timeout_p)) wd_cnt <= wd_cnt + 1'b1;
      if (err_now && !err_seen) begin
        err_seen    <= 1'b1;
        timeout_o   <= wd_err;
        err_vaddr_o <= (data_err && empty) ? '0 : head_vaddr;
        err_exp_o   <= (data_err && empty) ? '0 : head_instr;
        err_act_o   <= wd_err ? '0 : data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (halted == 1'b0 && err_now && exp_ready_o == 1'b0) state_n = FAIL;
`ifdef BP_FE_FETCH_CHECKER_HALT_ON_ERR_EN
        if (err_now)     state_n = FAIL;
        else if (push)   state_n = RUN;
        else if (done_i) state_n = PASS;
`else
        if (push)        state_n = RUN;
        else if (done_i) state_n = (err_seen || err_now) ? FAIL : PASS;
`endif
      end
      RUN: begin
`ifdef BP_FE_FETCH_CHECKER_HALT_ON_ERR_EN
        if (err_now)     state_n = FAIL;
        else if (done_i) state_n = DRAIN;
`else
        if (done_i)      state_n = DRAIN;
`endif
      end
      DRAIN: begin
        if (err_seen || err_now) state_n = FAIL;
        else if (empty)          state_n = PASS;
      end
      PASS:    if (err_now) state_n = FAIL;
      FAIL:    state_n = FAIL;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    done_o = 1'b0;
    pass_o = 1'b0;
    fail_o = 1'b0;
    case (state)
      PASS:    begin done_o = 1'b1; pass_o = 1'b1; end
      FAIL:    begin done_o = 1'b1; fail_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bp_fe_icache_fetch_checker.sv
// Directed and randomized bench for bp_fe_icache_fetch_checker with a queue-based reference model.
module tb_bp_fe_icache_fetch_checker;
  localparam int VW = 39, IW = 32, ELS = 8, TO = 64, CW = 4, OW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, exp_v, exp_ready, data_v, done_in;
  logic [VW-1:0] exp_vaddr, err_vaddr;
  logic [IW-1:0] exp_instr, data, err_exp, err_act;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] match_cnt, mismatch_cnt;
  logic done_out, pass, fail, timeout;

  bp_fe_icache_fetch_checker #(.vaddr_width_p(VW), .instr_width_p(IW), .els_p(ELS),
                               .timeout_p(TO), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .exp_v_i(exp_v), .exp_ready_o(exp_ready),
    .exp_vaddr_i(exp_vaddr), .exp_instr_i(exp_instr), .data_v_i(data_v), .data_i(data),
    .done_i(done_in), .outstanding_o(outstanding), .match_cnt_o(match_cnt),
    .mismatch_cnt_o(mismatch_cnt), .done_o(done_out), .pass_o(pass), .fail_o(fail),
    .timeout_o(timeout), .err_vaddr_o(err_vaddr), .err_exp_o(err_exp), .err_act_o(err_act));

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_v = 0; data_v = 0; done_in = 0;
    reset_n = 0;
    #7;
    reset_n = 1;
    step();
  endtask

  task automatic push(input logic [VW-1:0] va, input logic [IW-1:0] ins);
    exp_v = 1; exp_vaddr = va; exp_instr = ins;
    step();
    exp_v = 0;
  endtask

  task automatic ret(input logic [IW-1:0] d);
    data_v = 1; data = d;
    step();
    data_v = 0;
  endtask

  task automatic finish_run(input string tag);
    int n;
    done_in = 1;
    step();
    done_in = 0;
    n = 0;
    while (!done_out && n < 10) begin
      step();
      n++;
    end
    check({tag, "_done"}, done_out, 1);
  endtask

  logic [VW-1:0] qv[$];
  logic [IW-1:0] qi[$];
  int model_match;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n = 0; exp_v = 0; data_v = 0; done_in = 0;
    exp_vaddr = '0; exp_instr = '0; data = '0;
    #12;
    check("rst_outstanding", outstanding, 0);
    check("rst_ready", exp_ready, 1);
    check("rst_match", match_cnt, 0);
    check("rst_done", done_out, 0);
    check("rst_pass_fail", {pass, fail, timeout}, 0);
    check("rst_err_vaddr", err_vaddr, 0);
    reset_n = 1;
    step();

    // 1: four in-order hits then pass
    do_reset();
    for (int i = 0; i < 4; i++) push(VW'(64'h8000_0000 + 4*i), IW'(32'h13 + 32'h80*i));
    check("t1_outstanding4", outstanding, 4);
    for (int i = 0; i < 4; i++) ret(IW'(32'h13 + 32'h80*i));
    finish_run("t1");
    check("t1_match", match_cnt, 4);
    check("t1_pass", {pass, fail}, 2'b10);
    check("t1_outstanding", outstanding, 0);

    // 2: full FIFO refuses a push even while popping
    do_reset();
    for (int i = 0; i < 8; i++) push(VW'(64'h8000_1000 + 4*i), IW'(32'h1000 + i));
    check("t2_full_ready", exp_ready, 0);
    exp_v = 1; exp_vaddr = VW'(64'h8000_2000); exp_instr = 32'hdead;
    data_v = 1; data = 32'h1000;
    step();
    exp_v = 0; data_v = 0;
    check("t2_outstanding7", outstanding, 7);
    check("t2_ready_again", exp_ready, 1);
    for (int i = 1; i < 8; i++) ret(IW'(32'h1000 + i));
    check("t2_outstanding0", outstanding, 0);
    check("t2_match", match_cnt, 8);
    check("t2_mismatch", mismatch_cnt, 0);

    // 3: data mismatch capture
    do_reset();
    push(VW'(64'h8000_0004), 32'h13);
    ret(32'h33);
    check("t3_mismatch", mismatch_cnt, 1);
    check("t3_match", match_cnt, 0);
    check("t3_err_vaddr", err_vaddr, 64'h8000_0004);
    check("t3_err_exp", err_exp, 32'h13);
    check("t3_err_act", err_act, 32'h33);
    finish_run("t3");
    check("t3_fail", {pass, fail, timeout}, 3'b010);

    // 4: unexpected return while pushing into an empty FIFO
    do_reset();
    exp_v = 1; exp_vaddr = VW'(64'h8000_0010); exp_instr = 32'h55;
    data_v = 1; data = 32'h77;
    step();
    exp_v = 0; data_v = 0;
    check("t4_mismatch", mismatch_cnt, 1);
    check("t4_err_exp", err_exp, 0);
    check("t4_err_vaddr", err_vaddr, 0);
    check("t4_err_act", err_act, 32'h77);
    check("t4_outstanding", outstanding, 1);

    // 5: watchdog
    do_reset();
    push(VW'(64'h8000_0040), 32'h99);
    begin
      int n;
      n = 0;
      while (!timeout && n < TO + 5) begin
        step();
        n++;
      end
      check("t5_timeout_cycle", n, TO);
    end
    check("t5_timeout", timeout, 1);
    check("t5_err_vaddr", err_vaddr, 64'h8000_0040);
    finish_run("t5");
    check("t5_fail", {pass, fail}, 2'b01);

    // 6: async reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) push(VW'(64'h8000_0000 + 4*i), IW'(32'h200 + i));
    ret(32'h200);
    check("t6_pre_outstanding", outstanding, 3);
    check("t6_pre_match", match_cnt, 1);
    #2;
    reset_n = 0;
    #1;
    check("t6_outstanding", outstanding, 0);
    check("t6_counters", {match_cnt, mismatch_cnt}, 0);
    check("t6_done", done_out, 0);
    check("t6_ready", exp_ready, 1);
    #3;
    reset_n = 1;
    step();

    // Random traffic against the queue model; match counter saturates at 15.
    do_reset();
    qv.delete(); qi.delete();
    model_match = 0;
    for (int c = 0; c < 400; c++) begin
      bit do_push, do_ret;
      int sz;
      logic [VW-1:0] va;
      logic [IW-1:0] ins;
      sz = qv.size();
      check("rnd_ready", exp_ready, (sz < ELS));
      do_push = ($urandom_range(0, 1) == 1);
      do_ret  = (sz > 0) && ($urandom_range(0, 9) < 4);
      va  = VW'({$urandom, $urandom});
      ins = $urandom;
      exp_v = do_push; exp_vaddr = va; exp_instr = ins;
      data_v = do_ret; data = do_ret ? qi[0] : $urandom;
      step();
      exp_v = 0; data_v = 0;
      if (do_ret) begin
        void'(qv.pop_front());
        void'(qi.pop_front());
        model_match++;
      end
      if (do_push && sz < ELS) begin
        qv.push_back(va);
        qi.push_back(ins);
      end
      check("rnd_outstanding", outstanding, qv.size());
      check("rnd_match", match_cnt, (model_match > 15) ? 15 : model_match);
      check("rnd_mismatch", mismatch_cnt, 0);
    end
    while (qi.size() > 0) begin
      ret(qi[0]);
      void'(qv.pop_front());
      void'(qi.pop_front());
    end
    finish_run("rnd");
    check("rnd_pass", {pass, fail, timeout}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
